// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer: fetch, operand/accumulator reads through the
// register file select port, writeback via its write port, plus PC and Z/C flags.
module ctrl_seq #(
  parameter  int WIDTH = 3,
  parameter  int SIZE  = 11,
  parameter  int OPD_W = 4,
  parameter  int PC_W  = 8,
  localparam int SELW  = $clog2(SIZE),
  localparam int IW    = 4 + OPD_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic [IW-1:0]    instr_i,
  output logic [PC_W-1:0]  pc_o,
  output logic [SELW-1:0]  rf_sel_o,
  output logic             rf_en_o,
  output logic [WIDTH-1:0] rf_in_o,
  input  logic [WIDTH-1:0] rf_out_i,
  output logic             z_o,
  output logic             c_o,
  output logic             halted_o
);

  typedef enum logic [2:0] {
    S_FETCH, S_RD_OPR, S_RD_ACC, S_WB, S_JUMP, S_HALT
  } state_e;

  localparam logic [3:0] OP_LD  = 4'h1, OP_ST  = 4'h2, OP_ADD = 4'h3, OP_SUB = 4'h4,
                         OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7, OP_NOT = 4'h8,
                         OP_JMP = 4'h9, OP_JZ  = 4'hA, OP_JC  = 4'hB, OP_HLT = 4'hF;
  localparam logic [SELW-1:0] ACC_IDX = SELW'(2);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [IW-1:0]     ir_q, ir_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic              z_q, z_d, c_q, c_d;

  logic [3:0]        op, f_op;
  logic [OPD_W-1:0]  opd;
  logic [SELW-1:0]   opd_sel;
  logic [WIDTH:0]    sum, diff;
  logic [WIDTH-1:0]  result;
  logic              taken;

  assign op      = ir_q[IW-1:OPD_W];
  assign opd     = ir_q[OPD_W-1:0];
  assign opd_sel = opd[SELW-1:0];
  assign f_op    = instr_i[IW-1:OPD_W];

  // Extra top bit of diff is the unsigned borrow (A < B).
  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    result = '0;
    case (op)
      OP_LD:   result = b_q;
      OP_ST:   result = a_q;
      OP_ADD:  result = sum[WIDTH-1:0];
      OP_SUB:  result = diff[WIDTH-1:0];
      OP_AND:  result = a_q & b_q;
      OP_OR:   result = a_q | b_q;
      OP_XOR:  result = a_q ^ b_q;
      OP_NOT:  result = ~a_q;
      default: result = '0;
    endcase
  end

  assign taken = (op == OP_JMP) || ((op == OP_JZ) && z_q) || ((op == OP_JC) && c_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
    c_d     = c_q;
    case (state_q)
      S_FETCH: begin
        if (run_i) begin
          ir_d = instr_i;
          case (f_op)
            OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_d = S_RD_OPR;
            OP_ST, OP_NOT:                                state_d = S_RD_ACC;
            OP_HLT:                                       state_d = S_HALT;
            default:                                      state_d = S_JUMP;
          endcase
        end
      end
      S_RD_OPR: begin
        b_d     = rf_out_i;
        state_d = (op == OP_LD) ? S_WB : S_RD_ACC;
      end
      S_RD_ACC: begin
        a_d     = rf_out_i;
        state_d = S_WB;
      end
      S_WB: begin
        pc_d = pc_q + PC_W'(1);
        if (op != OP_ST) z_d = (result == '0);
        if (op == OP_ADD) c_d = sum[WIDTH];
        else if (op == OP_SUB) c_d = diff[WIDTH];
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_d    = taken ? PC_W'(opd) : pc_q + PC_W'(1);
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Write enable is masked by reset so an interrupted WB never commits.
  always_comb begin
    rf_sel_o = '0;
    rf_en_o  = 1'b0;
    rf_in_o  = '0;
    case (state_q)
      S_RD_OPR: rf_sel_o = opd_sel;
      S_RD_ACC: rf_sel_o = ACC_IDX;
      S_WB: begin
        rf_sel_o = (op == OP_ST) ? opd_sel : ACC_IDX;
        rf_en_o  = ~rst_i;
        rf_in_o  = result;
      end
      default: ;
    endcase
  end

  assign pc_o     = pc_q;
  assign z_o      = z_q;
  assign c_o      = c_q;
  assign halted_o = (state_q == S_HALT);

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: instruction-level reference model checked every cycle,
// plus directed programs with hand-computed literal expectations.
module tb_ctrl_seq;
  localparam int NREG = 11;

  logic       clk = 1'b0, rst = 1'b1, run = 1'b0, rf_load = 1'b1;
  logic [7:0] instr, pc;
  logic [3:0] sel;
  logic       en, z, c, halted;
  logic [2:0] rin, rout;
  logic [7:0] prog [256];
  logic [2:0] rf [NREG];
  logic [2:0] rf_init [NREG];
  int n_checks = 0, n_fail = 0;

  ctrl_seq dut (
    .clk_i(clk), .rst_i(rst), .run_i(run), .instr_i(instr), .pc_o(pc),
    .rf_sel_o(sel), .rf_en_o(en), .rf_in_o(rin), .rf_out_i(rout),
    .z_o(z), .c_o(c), .halted_o(halted)
  );

  always #5 clk = ~clk;

  // Program memory and register file live in the bench.
  assign instr = prog[pc];
  assign rout  = (sel < 4'(NREG)) ? rf[sel] : 3'd0;
  always @(posedge clk) begin
    if (rf_load) rf <= rf_init;
    else if (en && sel < 4'(NREG)) rf[sel] <= rin;
  end

  typedef enum {K_PC, K_Z, K_C, K_HALT, K_EN, K_SEL, K_IN, K_ACC, K_R1, K_R4} kind_e;
  typedef struct { string name; kind_e k; int exp; } lit_t;
  typedef struct { int sel; int en; int din; } rec_t;
  lit_t lits[$];
  rec_t q[$];

  int m_pc, m_z, m_c, m_halt;
  int mR [NREG];
  int p_pc, p_z, p_c, p_wr, p_idx, p_val;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_lit(input string name, input kind_e k, input int e);
    lits.push_back('{name, k, e});
  endtask

  // ISA-level execution of one instruction: its bus activity per cycle after
  // FETCH, plus the architectural effects that land when it completes.
  task automatic model_fetch();
    int ins, op, a, acc, b, res, wi;
    ins = prog[m_pc]; op = ins / 16; a = ins % 16;
    acc = mR[2]; b = (a < NREG) ? mR[a] : 0;
    p_pc = (m_pc + 1) % 256; p_z = m_z; p_c = m_c; p_wr = 0; res = 0;
    case (op)
      1: begin res = b; q.push_back('{a, 0, 0}); end
      2: begin res = acc; q.push_back('{2, 0, 0}); end
      3: begin res = (acc + b) % 8; p_c = (acc + b > 7) ? 1 : 0; end
      4: begin res = (acc - b + 8) % 8; p_c = (acc < b) ? 1 : 0; end
      5: res = acc & b;
      6: res = acc | b;
      7: res = acc ^ b;
      8: begin res = 7 - acc; q.push_back('{2, 0, 0}); end
      default: ;
    endcase
    if (op >= 3 && op <= 7) begin
      q.push_back('{a, 0, 0});
      q.push_back('{2, 0, 0});
    end
    if (op >= 1 && op <= 8) begin
      wi = (op == 2) ? a : 2;
      q.push_back('{wi, 1, res});
      p_wr = (wi < NREG) ? 1 : 0; p_idx = wi; p_val = res;
      if (op != 2) p_z = (res == 0) ? 1 : 0;
    end else if (op == 15) begin
      m_halt = 1;
    end else begin
      q.push_back('{0, 0, 0});
      if (op == 9 || (op == 10 && m_z == 1) || (op == 11 && m_c == 1)) p_pc = a;
    end
  endtask

  always @(negedge clk) begin : cmp
    lit_t l;
    rec_t r;
    int act;
    while (lits.size() > 0) begin
      l = lits.pop_front();
      case (l.k)
        K_PC:    act = pc;
        K_Z:     act = z;
        K_C:     act = c;
        K_HALT:  act = halted;
        K_EN:    act = en;
        K_SEL:   act = sel;
        K_IN:    act = rin;
        K_ACC:   act = rf[2];
        K_R1:    act = rf[1];
        default: act = rf[4];
      endcase
      chk(l.name, act, l.exp);
    end
    if (rst) begin
      chk("rst_gates_en", en, 0);
      q.delete();
      m_pc = 0; m_z = 0; m_c = 0; m_halt = 0;
      if (rf_load) foreach (mR[i]) mR[i] = rf_init[i];
    end else begin
      chk("m_pc", pc, m_pc);
      chk("m_z", z, m_z);
      chk("m_c", c, m_c);
      chk("m_halted", halted, m_halt);
      if (q.size() > 0) begin
        r = q.pop_front();
        chk("m_sel", sel, r.sel);
        chk("m_en", en, r.en);
        chk("m_in", rin, r.din);
        if (q.size() == 0) begin
          m_pc = p_pc; m_z = p_z; m_c = p_c;
          if (p_wr == 1) mR[p_idx] = p_val;
        end
      end else begin
        chk("m_idle_sel", sel, 0);
        chk("m_idle_en", en, 0);
        chk("m_idle_in", rin, 0);
        if (m_halt == 0 && run) model_fetch();
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; rf_load = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; rf_load = 1'b0;
  endtask

  task automatic wait_pc(input int target, input int budget, input string name);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk); #1;
      if (pc == 8'(target)) found = 1'b1;
    end
    if (!found) expect_lit(name, K_PC, target);
  endtask

  task automatic wait_halt(input int budget, input string name);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(posedge clk); #1;
      if (halted) found = 1'b1;
    end
    if (!found) expect_lit(name, K_HALT, 1);
  endtask

  logic [7:0] prog_a [16] = '{8'h11, 8'h31, 8'h41, 8'h10, 8'hA6, 8'hF0, 8'h31, 8'hA5,
                              8'h13, 8'h24, 8'h80, 8'hB5, 8'h71, 8'h31, 8'hB5, 8'hF0};
  logic [7:0] prog_b [10] = '{8'h15, 8'h53, 8'h66, 8'h80, 8'h75, 8'h41, 8'h80, 8'h56,
                              8'h21, 8'hF0};

  initial begin
    foreach (prog[i]) prog[i] = 8'h00;
    for (int i = 0; i < 16; i++) prog[i] = prog_a[i];
    rf_init = '{3'd0, 3'd7, 3'd0, 3'd3, 3'd0, 3'd5, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0};

    // Reset state, then RUN low keeps the sequencer parked.
    do_reset();
    expect_lit("rst_pc", K_PC, 0);   expect_lit("rst_en", K_EN, 0);
    expect_lit("rst_sel", K_SEL, 0); expect_lit("rst_in", K_IN, 0);
    expect_lit("rst_z", K_Z, 0);     expect_lit("rst_c", K_C, 0);
    expect_lit("rst_halted", K_HALT, 0);
    repeat (10) @(posedge clk);
    #1 expect_lit("idle_pc", K_PC, 0); expect_lit("idle_en", K_EN, 0);

    // Program A: arithmetic, jumps, store, RUN pause, halt.
    do_reset();
    run = 1'b1;
    repeat (3) @(posedge clk);
    #1 expect_lit("ld_acc", K_ACC, 7); expect_lit("ld_z", K_Z, 0); expect_lit("ld_pc", K_PC, 1);
    repeat (3) @(posedge clk);
    #1 expect_lit("add_wb7_en", K_EN, 1); expect_lit("add_wb7_sel", K_SEL, 2);
    expect_lit("add_wb7_in", K_IN, 6);
    @(posedge clk);
    #1 expect_lit("add_acc", K_ACC, 6); expect_lit("add_c", K_C, 1);
    expect_lit("add_z", K_Z, 0); expect_lit("add_pc", K_PC, 2);
    wait_pc(4, 20, "to_pc4");
    expect_lit("ld0_acc", K_ACC, 0); expect_lit("ld0_z", K_Z, 1); expect_lit("ld0_c", K_C, 1);
    @(posedge clk);
    #1 run = 1'b0;
    repeat (6) @(posedge clk);
    #1 expect_lit("stall_pc", K_PC, 6); expect_lit("stall_en", K_EN, 0);
    run = 1'b1;
    wait_pc(9, 30, "to_pc9");
    repeat (2) @(posedge clk);
    #1 expect_lit("st_en", K_EN, 1); expect_lit("st_sel", K_SEL, 4); expect_lit("st_in", K_IN, 3);
    @(posedge clk);
    #1 expect_lit("st_r4", K_R4, 3); expect_lit("st_z", K_Z, 0); expect_lit("st_c", K_C, 0);
    wait_halt(60, "halt_a");
    expect_lit("a_pc", K_PC, 5); expect_lit("a_acc", K_ACC, 2); expect_lit("a_c", K_C, 1);
    run = 1'b0;
    repeat (3) @(posedge clk);
    #1 run = 1'b1;
    repeat (3) @(posedge clk);
    #1 expect_lit("hold_halted", K_HALT, 1); expect_lit("hold_pc", K_PC, 5);

    // Program B: logic ops, NOT, borrow, ST to a low index.
    for (int i = 0; i < 10; i++) prog[i] = prog_b[i];
    do_reset();
    expect_lit("hlt_cleared", K_HALT, 0); expect_lit("hlt_pc", K_PC, 0);
    run = 1'b1;
    wait_halt(80, "halt_b");
    expect_lit("b_acc", K_ACC, 0); expect_lit("b_z", K_Z, 1);
    expect_lit("b_c", K_C, 1); expect_lit("b_st1", K_R1, 0);

    // Reset landing on the ADD writeback cycle.
    for (int i = 0; i < 16; i++) prog[i] = prog_a[i];
    do_reset();
    run = 1'b1;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    expect_lit("rstwb_en", K_EN, 0); expect_lit("rstwb_acc", K_ACC, 7);
    @(posedge clk);
    #1 rst = 1'b0; run = 1'b0;
    expect_lit("rstwb_pc", K_PC, 0); expect_lit("rstwb_z", K_Z, 0);
    expect_lit("rstwb_c", K_C, 0); expect_lit("rstwb_acc_kept", K_ACC, 7);

    // PC wrap through NOPs, then JMP 0 from 255 into a self-loop.
    foreach (prog[i]) prog[i] = 8'h00;
    do_reset();
    run = 1'b1;
    wait_pc(255, 600, "to_pc255_a");
    repeat (2) @(posedge clk);
    #1 expect_lit("nop_wrap", K_PC, 0);
    wait_pc(5, 20, "to_pc5");
    prog[0] = 8'h90; prog[255] = 8'h90;
    wait_pc(255, 600, "to_pc255_b");
    repeat (2) @(posedge clk);
    #1 expect_lit("jmp_wrap", K_PC, 0);
    repeat (10) @(posedge clk);
    #1 expect_lit("self_loop", K_PC, 0);

    repeat (2) @(posedge clk);
    #1 $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
